control_sequencer: RTL and testbench

//  Microcode sequencer for the 8-bit SAP-style CPU. It steps a 6-state T-counter
//  (T0..T5) and decodes opcode, step and ALU flags into the 15-bit control word.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/t_state_counter.sv | 30 +++
 rtl/control_sequencer.sv | 128 ++++++++++++
 tb/tb_control_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the SAP-style CPU: opcodes, control-word
// bit positions, idle word and T-state encodings.
package cpu_pkg;

  typedef logic [14:0] ctrl_word_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CB_CP   = 14;
  localparam int CB_EP   = 13;
  localparam int CB_LP   = 12;
  localparam int CB_NLMA = 11;
  localparam int CB_NLMD = 10;
  localparam int CB_NCE  = 9;
  localparam int CB_NLR  = 8;
  localparam int CB_NLI  = 7;
  localparam int CB_NEI  = 6;
  localparam int CB_NLA  = 5;
  localparam int CB_EA   = 4;
  localparam int CB_SUB  = 3;
  localparam int CB_EU   = 2;
  localparam int CB_NLB  = 1;
  localparam int CB_NLO  = 0;

  // Active-low strobes sit high, everything else low.
  localparam ctrl_word_t IDLE_WORD = 15'h0FE3;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

endpackage

// File: rtl/t_state_counter.sv
// T-state counter: sync clear, hold when not enabled,
// wrap to T0 after the instruction's last step.
module t_state_counter
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       last,
  output logic [2:0] step
);

  logic [2:0] step_d;
  logic [2:0] step_q;

  always_comb begin
    step_d = step_q;
    if (!rst_n || clr)
      step_d = T0;
    else if (en)
      step_d = last ? T0 : step_q + 3'd1;
  end

  always_ff @(posedge clk)
    step_q <= step_d;

  assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: steps T0..T5 and decodes opcode, step
// and ALU flags into the 15-bit datapath control word.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_en,
  input  logic [3:0]  opcode,
  input  logic        cf,
  input  logic        zf,
  output logic [14:0] out,
  output logic [2:0]  step,
  output logic        halted
);

  ctrl_word_t cw;
  logic       last;
  logic       halt_take;
  logic       halted_d;
  logic       halted_q;
  logic       run;

  assign run       = step_en && !halted_q;
  assign halt_take = run && (step == T3) && (opcode == OP_HLT);

  t_state_counter u_tsc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (halt_take),
    .en    (run),
    .last  (last),
    .step  (step)
  );

  always_comb begin
    halted_d = halted_q;
    if (!rst_n)
      halted_d = 1'b0;
    else if (halt_take)
      halted_d = 1'b1;
  end

  always_ff @(posedge clk)
    halted_q <= halted_d;

  always_comb begin
    cw   = IDLE_WORD;
    last = 1'b0;
    case (step)
      T0: begin
        cw[CB_EP]   = 1'b1;
        cw[CB_NLMA] = 1'b0;
      end
      T1: cw[CB_CP] = 1'b1;
      T2: begin
        cw[CB_NCE] = 1'b0;
        cw[CB_NLI] = 1'b0;
      end
      T3: begin
        last = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CB_NEI]  = 1'b0;
            cw[CB_NLMA] = 1'b0;
            last        = 1'b0;
          end
          OP_LDI: begin
            cw[CB_NEI] = 1'b0;
            cw[CB_NLA] = 1'b0;
          end
          OP_JMP: begin
            cw[CB_NEI] = 1'b0;
            cw[CB_LP]  = 1'b1;
          end
          OP_JC: if (cf) begin
            cw[CB_NEI] = 1'b0;
            cw[CB_LP]  = 1'b1;
          end
          OP_JZ: if (zf) begin
            cw[CB_NEI] = 1'b0;
            cw[CB_LP]  = 1'b1;
          end
          OP_OUT: begin
            cw[CB_EA]  = 1'b1;
            cw[CB_NLO] = 1'b0;
          end
          default: ;
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            cw[CB_NCE] = 1'b0;
            cw[CB_NLA] = 1'b0;
            last       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CB_NCE] = 1'b0;
            cw[CB_NLB] = 1'b0;
          end
          OP_STA: begin
            cw[CB_EA]   = 1'b1;
            cw[CB_NLMD] = 1'b0;
          end
          default: last = 1'b1;
        endcase
      end
      T5: begin
        last = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB: begin
            cw[CB_EU]  = 1'b1;
            cw[CB_NLA] = 1'b0;
            cw[CB_SUB] = (opcode == OP_SUB);
          end
          OP_STA: cw[CB_NLR] = 1'b0;
          default: ;
        endcase
      end
      default: last = 1'b1;
    endcase
  end

  assign out    = (!rst_n || halted_q || !step_en) ? IDLE_WORD : cw;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, execute words,
// conditional jumps, halt, stall and mid-instruction reset.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step_en;
  logic [3:0]  opcode;
  logic        cf;
  logic        zf;
  logic [14:0] out;
  logic [2:0]  step;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [14:0] IDLE = 15'h0FE3;

  control_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_en (step_en),
    .opcode  (opcode),
    .cf      (cf),
    .zf      (zf),
    .out     (out),
    .step    (step),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] s,
                        input logic [14:0] w);
    chk({tag, ".step"}, {13'd0, step}, {13'd0, s});
    chk({tag, ".out"}, {1'b0, out}, {1'b0, w});
  endtask

  // Checks T0..T2 and leaves the sequencer sitting in T3.
  task automatic fetch(input string tag);
    chk_st({tag, ".T0"}, 3'd0, 15'h27E3);
    tick();
    chk_st({tag, ".T1"}, 3'd1, 15'h4FE3);
    tick();
    chk_st({tag, ".T2"}, 3'd2, 15'h0D63);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; step_en = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    tick();
    tick();
    chk_st("rst", 3'd0, IDLE);
    chk("rst.halted", {15'd0, halted}, 16'd0);
    rst_n = 1'b1;
    #1;

    fetch("lda");
    opcode = 4'h1; #1;
    chk_st("lda.T3", 3'd3, 15'h07A3);
    tick();
    chk_st("lda.T4", 3'd4, 15'h0DC3);
    tick();
    opcode = 4'h0; #1;
    chk_st("lda.wrap", 3'd0, 15'h27E3);

    fetch("sub");
    opcode = 4'h3; #1;
    chk_st("sub.T3", 3'd3, 15'h07A3);
    tick();
    chk_st("sub.T4", 3'd4, 15'h0DE1);
    tick();
    chk_st("sub.T5", 3'd5, 15'h0FCF);
    tick();
    chk("sub.wrap", {13'd0, step}, 16'd0);

    fetch("add");
    opcode = 4'h2; #1;
    tick();
    tick();
    chk_st("add.T5", 3'd5, 15'h0FC7);
    tick();
    chk("add.wrap", {13'd0, step}, 16'd0);

    fetch("sta");
    opcode = 4'h4; #1;
    chk_st("sta.T3", 3'd3, 15'h07A3);
    tick();
    chk_st("sta.T4", 3'd4, 15'h0BF3);
    tick();
    chk_st("sta.T5", 3'd5, 15'h0EE3);
    tick();
    chk("sta.wrap", {13'd0, step}, 16'd0);

    cf = 1'b1; #1;
    fetch("jc1");
    opcode = 4'h7; #1;
    chk_st("jc1.T3", 3'd3, 15'h1FA3);
    tick();
    chk("jc1.wrap", {13'd0, step}, 16'd0);

    fetch("jc0");
    cf = 1'b0; #1;
    chk_st("jc0.T3", 3'd3, IDLE);
    tick();
    chk("jc0.wrap", {13'd0, step}, 16'd0);

    zf = 1'b1; #1;
    fetch("jz1");
    opcode = 4'h8; #1;
    chk_st("jz1.T3", 3'd3, 15'h1FA3);
    tick();
    chk("jz1.wrap", {13'd0, step}, 16'd0);

    fetch("jz0");
    zf = 1'b0; #1;
    chk_st("jz0.T3", 3'd3, IDLE);
    tick();
    chk("jz0.wrap", {13'd0, step}, 16'd0);

    fetch("ldi");
    opcode = 4'h5; #1;
    chk_st("ldi.T3", 3'd3, 15'h0F83);
    tick();
    fetch("jmp");
    opcode = 4'h6; #1;
    chk_st("jmp.T3", 3'd3, 15'h1FA3);
    tick();
    fetch("outi");
    opcode = 4'hE; #1;
    chk_st("outi.T3", 3'd3, 15'h0FF2);
    tick();
    fetch("undef");
    opcode = 4'hA; #1;
    chk_st("undef.T3", 3'd3, IDLE);
    tick();
    chk("undef.wrap", {13'd0, step}, 16'd0);

    fetch("hlt");
    opcode = 4'hF; #1;
    chk_st("hlt.T3", 3'd3, IDLE);
    chk("hlt.T3.halted", {15'd0, halted}, 16'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk_st("hlt.hold", 3'd0, IDLE);
      chk("hlt.halted", {15'd0, halted}, 16'd1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("hlt.rst.halted", {15'd0, halted}, 16'd0);
    chk_st("hlt.rst", 3'd0, IDLE);
    rst_n = 1'b1; opcode = 4'h2; #1;

    fetch("stall");
    chk_st("stall.T3", 3'd3, 15'h07A3);
    tick();
    chk_st("stall.T4", 3'd4, 15'h0DE1);
    step_en = 1'b0; #1;
    chk_st("stall.off", 3'd4, IDLE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("stall.hold", 3'd4, IDLE);
    end
    step_en = 1'b1; #1;
    chk_st("stall.resume", 3'd4, 15'h0DE1);
    tick();
    chk_st("stall.T5", 3'd5, 15'h0FC7);
    rst_n = 1'b0; #1;
    chk_st("midrst.T5", 3'd5, IDLE);
    tick();
    chk_st("midrst", 3'd0, IDLE);
    rst_n = 1'b1; #1;
    chk_st("midrst.fetch", 3'd0, 15'h27E3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
